// File: rtl/axi_aw_sched_pkg.sv
// Shared types and helpers for the AXI write-address round-robin scheduler.
// Optional QoS-first arbitration is enabled by defining AXI_AW_QOS_EN.
package axi_aw_sched_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int QOS_W = 4;

  // Fixed-width AW attributes; parameter-sized id/addr/user travel alongside.
  typedef struct packed {
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    logic             lock;
    logic [3:0]       cache;
    logic [2:0]       prot;
    logic [3:0]       region;
    logic [QOS_W-1:0] qos;
  } aw_fields_t;

  function automatic logic [31:0] onehot(input logic [4:0] idx);
    return 32'd1 << idx;
  endfunction

  function automatic logic [4:0] bin(input logic [31:0] oh);
    logic [4:0] res;
    res = '0;
    for (int i = 31; i >= 0; i--) begin
      if (oh[i]) res = 5'(i);
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_aw_rr_pick.sv
// Combinational rotate-priority picker: first candidate at or after ptr, wrapping.
// With AXI_AW_QOS_EN defined, candidates are restricted to the highest-QoS requesters.
module axi_aw_rr_pick
  import axi_aw_sched_pkg::*;
#(
  parameter int N_TARG_PORT = 7,
  parameter int LOG_N_TARG  = $clog2(N_TARG_PORT)
) (
  input  logic [N_TARG_PORT-1:0]       req,
  input  logic [LOG_N_TARG-1:0]        ptr,
`ifdef AXI_AW_QOS_EN
  input  logic [N_TARG_PORT*QOS_W-1:0] qos,
`endif
  output logic                         gnt_valid,
  output logic [LOG_N_TARG-1:0]        win
);

  logic [N_TARG_PORT-1:0] cand;

`ifdef AXI_AW_QOS_EN
  logic [QOS_W-1:0] max_qos;

  always_comb begin
    max_qos = '0;
    cand    = '0;
    for (int i = 0; i < N_TARG_PORT; i++) begin
      if (req[i] && (qos[i*QOS_W +: QOS_W] > max_qos)) max_qos = qos[i*QOS_W +: QOS_W];
    end
    for (int i = 0; i < N_TARG_PORT; i++) begin
      cand[i] = req[i] && (qos[i*QOS_W +: QOS_W] == max_qos);
    end
  end
`else
  assign cand = req;
`endif

  always_comb begin
    gnt_valid = 1'b0;
    win       = '0;
    for (int i = 0; i < N_TARG_PORT; i++) begin
      int idx;
      idx = int'(ptr) + i;
      if (idx >= N_TARG_PORT) idx = idx - N_TARG_PORT;
      if (!gnt_valid && cand[idx]) begin
        gnt_valid = 1'b1;
        win       = LOG_N_TARG'(idx);
      end
    end
  end

endmodule

// File: rtl/axi_aw_rr_scheduler.sv
// Round-robin AW scheduler: muxes N slave AW requests onto one master AW and pushes {bin,onehot}
// of each accepted winner to the W allocator ID FIFO. AXI_AW_QOS_EN selects QoS-first arbitration.
module axi_aw_rr_scheduler
  import axi_aw_sched_pkg::*;
#(
  parameter int N_TARG_PORT = 7,
  parameter int LOG_N_TARG  = $clog2(N_TARG_PORT),
  parameter int AXI_ID_IN   = 4,
  parameter int AXI_ADDR_W  = 32,
  parameter int AXI_USER_W  = 6
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [N_TARG_PORT*AXI_ID_IN-1:0]  awid_i,
  input  logic [N_TARG_PORT*AXI_ADDR_W-1:0] awaddr_i,
  input  logic [N_TARG_PORT*8-1:0]          awlen_i,
  input  logic [N_TARG_PORT*3-1:0]          awsize_i,
  input  logic [N_TARG_PORT*2-1:0]          awburst_i,
  input  logic [N_TARG_PORT-1:0]            awlock_i,
  input  logic [N_TARG_PORT*4-1:0]          awcache_i,
  input  logic [N_TARG_PORT*3-1:0]          awprot_i,
  input  logic [N_TARG_PORT*4-1:0]          awregion_i,
  input  logic [N_TARG_PORT*AXI_USER_W-1:0] awuser_i,
  input  logic [N_TARG_PORT*4-1:0]          awqos_i,
  input  logic [N_TARG_PORT-1:0]            awvalid_i,
  output logic [N_TARG_PORT-1:0]            awready_o,
  output logic [LOG_N_TARG+AXI_ID_IN-1:0]   awid_o,
  output logic [AXI_ADDR_W-1:0]             awaddr_o,
  output logic [7:0]                        awlen_o,
  output logic [2:0]                        awsize_o,
  output logic [1:0]                        awburst_o,
  output logic                              awlock_o,
  output logic [3:0]                        awcache_o,
  output logic [2:0]                        awprot_o,
  output logic [3:0]                        awregion_o,
  output logic [AXI_USER_W-1:0]             awuser_o,
  output logic [3:0]                        awqos_o,
  output logic                              awvalid_o,
  input  logic                              awready_i,
  output logic                              push_ID_o,
  output logic [LOG_N_TARG+N_TARG_PORT-1:0] ID_o,
  input  logic                              grant_FIFO_ID_i
);

  state_t                  state_reg, state_next;
  logic [LOG_N_TARG-1:0]   ptr_reg, win_reg, sel, ptr_next;
  logic [LOG_N_TARG-1:0]   pick_win;
  logic                    pick_valid, handshake;
  logic [31:0]             sel_oh;
  aw_fields_t              attr_sel;

  logic [AXI_ID_IN-1:0]    id_arr   [N_TARG_PORT];
  logic [AXI_ADDR_W-1:0]   addr_arr [N_TARG_PORT];
  logic [AXI_USER_W-1:0]   user_arr [N_TARG_PORT];
  aw_fields_t              attr_arr [N_TARG_PORT];

  genvar gi;
  generate
    for (gi = 0; gi < N_TARG_PORT; gi++) begin : g_port
      assign id_arr[gi]   = awid_i[gi*AXI_ID_IN +: AXI_ID_IN];
      assign addr_arr[gi] = awaddr_i[gi*AXI_ADDR_W +: AXI_ADDR_W];
      assign user_arr[gi] = awuser_i[gi*AXI_USER_W +: AXI_USER_W];
      assign attr_arr[gi] = '{len:    awlen_i[gi*8 +: 8],    size:  awsize_i[gi*3 +: 3],
                              burst:  awburst_i[gi*2 +: 2],  lock:  awlock_i[gi],
                              cache:  awcache_i[gi*4 +: 4],  prot:  awprot_i[gi*3 +: 3],
                              region: awregion_i[gi*4 +: 4], qos:   awqos_i[gi*4 +: 4]};
    end
  endgenerate

  axi_aw_rr_pick #(
    .N_TARG_PORT (N_TARG_PORT),
    .LOG_N_TARG  (LOG_N_TARG)
  ) u_pick (
    .req       (awvalid_i),
    .ptr       (ptr_reg),
`ifdef AXI_AW_QOS_EN
    .qos       (awqos_i),
`endif
    .gnt_valid (pick_valid),
    .win       (pick_win)
  );

  assign ptr_next = (sel == LOG_N_TARG'(N_TARG_PORT - 1)) ? '0 : sel + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ARB;
      ptr_reg   <= '0;
      win_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (handshake) ptr_reg <= ptr_next;
      if (state_reg == ARB && awvalid_o && !awready_i) win_reg <= pick_win;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ARB:     if (awvalid_o && !awready_i) state_next = HOLD;
      HOLD:    if (handshake) state_next = ARB;
      default: state_next = ARB;
    endcase
  end

  // Once committed in HOLD, valid follows only the latched port; the FIFO check was done in ARB.
  always_comb begin
    sel       = !rst_n ? '0 : ((state_reg == HOLD) ? win_reg : pick_win);
    awvalid_o = rst_n && ((state_reg == HOLD) ? awvalid_i[win_reg]
                                              : (pick_valid && grant_FIFO_ID_i));
    sel_oh    = onehot(5'(sel));
    awready_o = handshake ? sel_oh[N_TARG_PORT-1:0] : '0;
    push_ID_o = handshake;
    ID_o      = {sel, sel_oh[N_TARG_PORT-1:0]};
    attr_sel  = attr_arr[sel];
    awid_o    = {sel, id_arr[sel]};
    awaddr_o  = addr_arr[sel];
    awuser_o  = user_arr[sel];
    awlen_o   = attr_sel.len;
    awsize_o  = attr_sel.size;
    awburst_o = attr_sel.burst;
    awlock_o  = attr_sel.lock;
    awcache_o = attr_sel.cache;
    awprot_o  = attr_sel.prot;
    awregion_o = attr_sel.region;
    awqos_o   = attr_sel.qos;
  end

  assign handshake = awvalid_o && awready_i;

endmodule
